// File: rtl/cpu_wb_bridge.sv
// Registered CPU valid/ready to Wishbone master bridge with a bus timeout.
// Define CPU_WB_BRIDGE_PIPELINED_EN for pipelined Wishbone (stb/stall); classic otherwise.
module cpu_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_wdata,
    input  logic [31:0] wb_rdata,
    input  logic        wb_ack,
    input  logic        wb_stall,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } state_t;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_d;
    logic [31:0] r_cnt, w_cnt_d;
    logic [31:0] r_addr, w_addr_d;
    logic [31:0] r_wdata, w_wdata_d;
    logic        r_we, w_we_d;
    logic [31:0] r_rdata, w_rdata_d;
    logic        r_terr, w_terr_d;
    logic        w_ack_ok;
    logic        w_to_hit;

`ifdef CPU_WB_BRIDGE_PIPELINED_EN
    logic        r_stb_pend, w_stb_pend_d;

    // An ack is only meaningful once the request has been accepted (or in the accept cycle).
    assign w_ack_ok = wb_ack && !(r_stb_pend && wb_stall);
`else
    logic        w_unused_stall;

    assign w_unused_stall = wb_stall;
    assign w_ack_ok       = wb_ack;
`endif

    assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TimeoutLast);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_terr     <= 1'b0;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
            r_stb_pend <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_we       <= w_we_d;
            r_rdata    <= w_rdata_d;
            r_terr     <= w_terr_d;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
            r_stb_pend <= w_stb_pend_d;
`endif
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_we_d       = r_we;
        w_rdata_d    = r_rdata;
        w_terr_d     = 1'b0;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
        w_stb_pend_d = r_stb_pend;
`endif
        unique case (r_state)
            StIdle: begin
                if (cpu_valid) begin
                    w_addr_d     = cpu_addr;
                    w_wdata_d    = cpu_wdata;
                    w_we_d       = cpu_we;
                    w_cnt_d      = '0;
                    w_state_d    = StBus;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
                    w_stb_pend_d = 1'b1;
`endif
                end
            end
            StBus: begin
                // Ack takes priority over a coincident timeout.
                if (w_ack_ok) begin
                    if (!r_we) begin
                        w_rdata_d = wb_rdata;
                    end
                    w_state_d = StResp;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
                    w_stb_pend_d = 1'b0;
`endif
                end else if (w_to_hit) begin
                    if (!r_we) begin
                        w_rdata_d = ERR_DATA;
                    end
                    w_terr_d  = 1'b1;
                    w_state_d = StResp;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
                    w_stb_pend_d = 1'b0;
`endif
                end else begin
                    w_cnt_d = r_cnt + 32'd1;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
                    if (r_stb_pend && !wb_stall) begin
                        w_stb_pend_d = 1'b0;
                    end
`endif
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs decode the state register directly so reset drops cyc/stb asynchronously.
    assign wb_cyc      = (r_state == StBus);
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
    assign wb_stb      = wb_cyc && r_stb_pend;
`else
    assign wb_stb      = wb_cyc;
`endif
    assign wb_sel      = wb_cyc ? 4'hF : 4'h0;
    assign wb_we       = r_we;
    assign wb_addr     = r_addr;
    assign wb_wdata    = r_wdata;
    assign cpu_rdata   = r_rdata;
    assign cpu_ready   = (r_state == StResp);
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Self-checking bench for cpu_wb_bridge: directed cases then random transactions
// against a cycle-count/data model derived from the bridge's transaction rules.
module tb_cpu_wb_bridge;

    localparam int unsigned N       = 8;
    localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic        wb_stall;
    logic        timeout_err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata;

    cpu_wb_bridge #(
        .TIMEOUT_CYCLES(N),
        .ERR_DATA      (ErrData)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cpu_valid  (cpu_valid),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_sel     (wb_sel),
        .wb_addr    (wb_addr),
        .wb_wdata   (wb_wdata),
        .wb_rdata   (wb_rdata),
        .wb_ack     (wb_ack),
        .wb_stall   (wb_stall),
        .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // ack_at: BUS-cycle index of the slave ack (negative = dead slave).
    // stall_n: cycles of wb_stall before acceptance (pipelined build only).
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] sdata, input int ack_at, input int stall_n);
        bit tout;
        int last;
        bit exp_stb;
        tout = (ack_at < 0) || (ack_at >= int'(N));
        last = tout ? int'(N) - 1 : ack_at;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick();
        for (int k = 0; k <= last; k++) begin
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
            exp_stb  = (k <= stall_n);
            wb_stall = (k < stall_n);
`else
            exp_stb  = 1'b1;
            wb_stall = 1'($urandom_range(0, 1));
`endif
            chk("bus_cyc", 32'(wb_cyc), 32'd1);
            chk("bus_stb", 32'(wb_stb), 32'(exp_stb));
            chk("bus_sel", 32'(wb_sel), 32'hF);
            chk("bus_addr", wb_addr, addr);
            chk("bus_wdata", wb_wdata, wdata);
            chk("bus_we", 32'(wb_we), 32'(we));
            chk("bus_ready", 32'(cpu_ready), 32'd0);
            wb_ack    = !tout && (k == ack_at);
            wb_rdata  = wb_ack ? sdata : $urandom;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_we    = 1'($urandom_range(0, 1));
            tick();
        end
        wb_ack   = 1'b0;
        wb_stall = 1'b0;
        if (!we) begin
            exp_rdata = tout ? ErrData : sdata;
        end
        chk("resp_ready", 32'(cpu_ready), 32'd1);
        chk("resp_terr", 32'(timeout_err), 32'(tout));
        chk("resp_rdata", cpu_rdata, exp_rdata);
        chk("resp_cyc", 32'(wb_cyc), 32'd0);
        cpu_valid = 1'b0;
        tick();
        chk("idle_ready", 32'(cpu_ready), 32'd0);
        chk("idle_terr", 32'(timeout_err), 32'd0);
        chk("idle_cyc", 32'(wb_cyc), 32'd0);
        chk("idle_rdata", cpu_rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int ack_at;
        int stall_n;
        logic we;

        rst_n     = 1'b0;
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        wb_rdata  = '0;
        wb_ack    = 1'b0;
        wb_stall  = 1'b0;
        exp_rdata = '0;
        #12;
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_sel", 32'(wb_sel), 32'd0);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_addr", wb_addr, 32'd0);
        chk("rst_wdata", wb_wdata, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Zero-wait read, 3-wait write, dead-slave read, then a normal read.
        txn(1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0);
        txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h5555_AAAA, 3, 0);
        txn(1'b0, 32'h0000_0200, 32'h0, 32'h0, -1, 0);
        txn(1'b0, 32'h0000_0204, 32'h0, 32'hA5A5_0001, 1, 0);

        // Spurious ack while idle.
        wb_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_rdata = $urandom;
            tick();
            chk("spur_ready", 32'(cpu_ready), 32'd0);
            chk("spur_cyc", 32'(wb_cyc), 32'd0);
            chk("spur_rdata", cpu_rdata, exp_rdata);
        end
        wb_ack = 1'b0;

        // Ack on the last cycle before timeout wins.
        txn(1'b0, 32'h0000_0300, 32'h0, 32'h0BAD_C0DE, int'(N) - 1, 0);

`ifdef CPU_WB_BRIDGE_PIPELINED_EN
        txn(1'b0, 32'h0000_0400, 32'h0, 32'h7777_8888, 3, 2);
`endif

        // Reset in the middle of a waiting bus cycle.
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0500;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_cyc", 32'(wb_cyc), 32'd0);
        chk("mrst_stb", 32'(wb_stb), 32'd0);
        chk("mrst_sel", 32'(wb_sel), 32'd0);
        chk("mrst_ready", 32'(cpu_ready), 32'd0);
        cpu_valid = 1'b0;
        exp_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_hold_ready", 32'(cpu_ready), 32'd0);
            chk("mrst_hold_rdata", cpu_rdata, exp_rdata);
        end
        rst_n = 1'b1;
        tick();
        txn(1'b0, 32'h0000_0504, 32'h0, 32'h600D_F00D, 2, 0);

        for (int t = 0; t < 24; t++) begin
            we = 1'($urandom_range(0, 1));
            ack_at = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 10));
            stall_n = 0;
`ifdef CPU_WB_BRIDGE_PIPELINED_EN
            stall_n = int'($urandom_range(0, 3));
            if (ack_at >= 0 && stall_n > ack_at) begin
                stall_n = ack_at;
            end
`endif
            txn(we, $urandom, $urandom, $urandom, ack_at, stall_n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
